sdram_pro_arbit: RTL and testbench

Command arbiter that sits directly downstream of the SDRAM FIFO controller. It takes the controller's `sdram_wr_req`/`sdram_rd_req`, the auto-refresh request, and the init-done flag. It grants exactly one SDRAM sub-engine at a time (init, auto-refresh, write or read) and multiplexes that engine's command, bank, address and write-data buses onto the SDRAM pins. Refresh has absolute priority; write and read alternate when both are pending.

---
 rtl/sdram_pro_arbit.sv | 129 ++++++++++++
 tb/tb_sdram_pro_arbit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_pro_arbit.sv
// SDRAM command arbiter: grants one sub-engine (init, refresh, write, read) at a time
// and muxes the granted engine's command/bank/address/DQ onto the SDRAM pins.
module sdram_pro_arbit #(
  parameter logic [3:0] NOP_CMD = 4'b0111,
  parameter int         DATA_W  = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              init_end,
  input  logic [3:0]        init_cmd,
  input  logic [1:0]        init_ba,
  input  logic [12:0]       init_addr,
  input  logic              aref_req,
  input  logic              aref_end,
  input  logic [3:0]        aref_cmd,
  input  logic [1:0]        aref_ba,
  input  logic [12:0]       aref_addr,
  input  logic              wr_req,
  input  logic              wr_end,
  input  logic [3:0]        wr_cmd,
  input  logic [1:0]        wr_ba,
  input  logic [12:0]       wr_addr,
  input  logic              wr_sdram_en,
  input  logic [DATA_W-1:0] wr_sdram_data,
  input  logic              rd_req,
  input  logic              rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [1:0]        rd_ba,
  input  logic [12:0]       rd_addr,
  output logic              aref_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [1:0]        sdram_ba,
  output logic [12:0]       sdram_addr,
  output logic [DATA_W-1:0] sdram_dq_out,
  output logic              sdram_dq_oe
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_AREF,
    S_WRITE,
    S_READ
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       last_grant;  // 0 = write granted last, 1 = read granted last
  logic [3:0] cmd;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= S_INIT;
      last_grant <= 1'b1;
      aref_en    <= 1'b0;
      wr_en      <= 1'b0;
      rd_en      <= 1'b0;
      sdram_cke  <= 1'b0;
    end else begin
      state     <= state_nxt;
      aref_en   <= (state_nxt == S_AREF);
      wr_en     <= (state_nxt == S_WRITE);
      rd_en     <= (state_nxt == S_READ);
      sdram_cke <= 1'b1;
      if (state == S_IDLE && state_nxt == S_WRITE) last_grant <= 1'b0;
      if (state == S_IDLE && state_nxt == S_READ)  last_grant <= 1'b1;
    end
  end

  // Refresh first; on a write/read tie the side not granted last wins.
  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:  if (init_end) state_nxt = S_IDLE;
      S_IDLE: begin
        if (aref_req)                state_nxt = S_AREF;
        else if (wr_req && rd_req)   state_nxt = last_grant ? S_WRITE : S_READ;
        else if (wr_req)             state_nxt = S_WRITE;
        else if (rd_req)             state_nxt = S_READ;
      end
      S_AREF:  if (aref_end) state_nxt = S_IDLE;
      S_WRITE: if (wr_end)   state_nxt = S_IDLE;
      S_READ:  if (rd_end)   state_nxt = S_IDLE;
      default: state_nxt = S_INIT;
    endcase
  end

  always_comb begin
    cmd          = NOP_CMD;
    sdram_ba     = 2'b11;
    sdram_addr   = 13'h1FFF;
    sdram_dq_out = '0;
    sdram_dq_oe  = 1'b0;
    case (state)
      S_INIT: begin
        cmd        = init_cmd;
        sdram_ba   = init_ba;
        sdram_addr = init_addr;
      end
      S_AREF: begin
        cmd        = aref_cmd;
        sdram_ba   = aref_ba;
        sdram_addr = aref_addr;
      end
      S_WRITE: begin
        cmd          = wr_cmd;
        sdram_ba     = wr_ba;
        sdram_addr   = wr_addr;
        sdram_dq_out = wr_sdram_data;
        sdram_dq_oe  = wr_sdram_en;
      end
      S_READ: begin
        cmd        = rd_cmd;
        sdram_ba   = rd_ba;
        sdram_addr = rd_addr;
      end
      default: ;
    endcase
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;

endmodule

// File: tb/tb_sdram_pro_arbit.sv
// Directed bench for sdram_pro_arbit: init hand-off, alternation, refresh priority,
// no preemption, stray end pulses and asynchronous reset mid-burst.
module tb_sdram_pro_arbit;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        init_end = 1'b0;
  logic [3:0]  init_cmd = 4'b0001;
  logic [1:0]  init_ba = 2'b00;
  logic [12:0] init_addr = 13'h0400;
  logic        aref_req = 1'b0, aref_end = 1'b0;
  logic [3:0]  aref_cmd = 4'b0010;
  logic [1:0]  aref_ba = 2'b01;
  logic [12:0] aref_addr = 13'h0111;
  logic        wr_req = 1'b0, wr_end = 1'b0;
  logic [3:0]  wr_cmd = 4'b0100;
  logic [1:0]  wr_ba = 2'b10;
  logic [12:0] wr_addr = 13'h0222;
  logic        wr_sdram_en = 1'b0;
  logic [15:0] wr_sdram_data = 16'h0000;
  logic        rd_req = 1'b0, rd_end = 1'b0;
  logic [3:0]  rd_cmd = 4'b0101;
  logic [1:0]  rd_ba = 2'b00;
  logic [12:0] rd_addr = 13'h0333;
  logic        aref_en, wr_en, rd_en, sdram_cke;
  logic        sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [1:0]  sdram_ba;
  logic [12:0] sdram_addr;
  logic [15:0] sdram_dq_out;
  logic        sdram_dq_oe;

  int errors = 0;
  int checks = 0;

  sdram_pro_arbit dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .init_end(init_end),
    .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr),
    .aref_req(aref_req), .aref_end(aref_end),
    .aref_cmd(aref_cmd), .aref_ba(aref_ba), .aref_addr(aref_addr),
    .wr_req(wr_req), .wr_end(wr_end),
    .wr_cmd(wr_cmd), .wr_ba(wr_ba), .wr_addr(wr_addr),
    .wr_sdram_en(wr_sdram_en), .wr_sdram_data(wr_sdram_data),
    .rd_req(rd_req), .rd_end(rd_end),
    .rd_cmd(rd_cmd), .rd_ba(rd_ba), .rd_addr(rd_addr),
    .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en), .sdram_cke(sdram_cke),
    .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
    .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
    .sdram_ba(sdram_ba), .sdram_addr(sdram_addr),
    .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  function automatic logic [31:0] pins();
    return {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_ba, sdram_addr};
  endfunction

  function automatic logic [2:0] ens();
    return {aref_en, wr_en, rd_en};
  endfunction

  localparam logic [31:0] P_INIT = {4'b0001, 2'b00, 13'h0400};
  localparam logic [31:0] P_NOP  = {4'b0111, 2'b11, 13'h1FFF};
  localparam logic [31:0] P_AREF = {4'b0010, 2'b01, 13'h0111};
  localparam logic [31:0] P_WR   = {4'b0100, 2'b10, 13'h0222};
  localparam logic [31:0] P_RD   = {4'b0101, 2'b00, 13'h0333};

  initial begin
    // Reset state, with write DQ drive asserted to show it is masked
    wr_sdram_en = 1'b1; wr_sdram_data = 16'hBEEF;
    step(); step();
    chk("rst_ens", 32'(ens()), 32'h0);
    chk("rst_cke", 32'(sdram_cke), 32'h0);
    chk("rst_pins", pins(), P_INIT);
    chk("rst_dq_oe", 32'(sdram_dq_oe), 32'h0);
    chk("rst_dq_out", 32'(sdram_dq_out), 32'h0);

    // INIT for 20 cycles; requests ignored
    sys_rst = 1'b0;
    wr_req = 1'b1; aref_req = 1'b1; rd_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("init_pins", pins(), P_INIT);
      chk("init_ens", 32'(ens()), 32'h0);
    end
    chk("init_cke", 32'(sdram_cke), 32'h1);
    wr_req = 1'b0; aref_req = 1'b0; rd_req = 1'b0;
    init_end = 1'b1;
    step();
    chk("idle_pins", pins(), P_NOP);
    chk("idle_ens", 32'(ens()), 32'h0);
    step();
    chk("idle_hold", pins(), P_NOP);

    // Contest: write wins first, then read
    wr_req = 1'b1; rd_req = 1'b1; wr_sdram_data = 16'hA5A5;
    step();
    chk("c1_wr_en", 32'(ens()), 32'b010);
    chk("c1_pins", pins(), P_WR);
    chk("c1_dq_oe", 32'(sdram_dq_oe), 32'h1);
    chk("c1_dq_out", 32'(sdram_dq_out), 32'hA5A5);
    wr_req = 1'b0;
    for (int i = 1; i < 10; i++) begin
      if (i == 4) begin
        rd_end = 1'b1; wr_sdram_en = 1'b0;
      end
      step();
      rd_end = 1'b0;
      chk("c1_wr_hold", 32'(ens()), 32'b010);
      if (i == 4) chk("c1_dq_oe_low", 32'(sdram_dq_oe), 32'h0);
      wr_sdram_en = 1'b1;
    end
    wr_end = 1'b1;
    step();
    wr_end = 1'b0;
    chk("c1_end_ens", 32'(ens()), 32'h0);
    chk("c1_end_pins", pins(), P_NOP);
    chk("c1_end_dq_oe", 32'(sdram_dq_oe), 32'h0);
    step();
    chk("c1_rd_en", 32'(ens()), 32'b001);
    chk("c1_rd_pins", pins(), P_RD);
    chk("c1_rd_dq_oe", 32'(sdram_dq_oe), 32'h0);
    rd_req = 1'b0;
    step();
    rd_end = 1'b1;
    step();
    rd_end = 1'b0;
    chk("c1_rd_end", 32'(ens()), 32'h0);

    // Second contest: write again; refresh arrives 3 cycles in and waits
    wr_req = 1'b1; rd_req = 1'b1;
    step();
    chk("c2_wr_en", 32'(ens()), 32'b010);
    wr_req = 1'b0;
    step(); step(); step();
    aref_req = 1'b1;
    step();
    chk("c2_no_preempt", 32'(ens()), 32'b010);
    step();
    chk("c2_no_preempt2", 32'(ens()), 32'b010);
    wr_end = 1'b1;
    step();
    wr_end = 1'b0;
    chk("c2_end_ens", 32'(ens()), 32'h0);
    step();
    chk("c2_aref_en", 32'(ens()), 32'b100);
    chk("c2_aref_pins", pins(), P_AREF);
    chk("c2_aref_dq_oe", 32'(sdram_dq_oe), 32'h0);
    aref_end = 1'b1; aref_req = 1'b0;
    step();
    aref_end = 1'b0;
    chk("c2_aref_end", 32'(ens()), 32'h0);
    step();
    chk("c2_rd_en", 32'(ens()), 32'b001);
    rd_req = 1'b0;

    // Asynchronous reset during READ
    step();
    sys_rst = 1'b1;
    #1;
    chk("ar_ens", 32'(ens()), 32'h0);
    chk("ar_cke", 32'(sdram_cke), 32'h0);
    chk("ar_pins", pins(), P_INIT);
    step();
    sys_rst = 1'b0;
    #1;
    chk("ar_init_after", pins(), P_INIT);
    step();
    chk("ar_idle", pins(), P_NOP);
    chk("ar_cke_back", 32'(sdram_cke), 32'h1);

    // Refresh and write together: refresh first, NOP, then write
    aref_req = 1'b1; wr_req = 1'b1;
    step();
    chk("aw_aref_en", 32'(ens()), 32'b100);
    aref_req = 1'b0;
    step();
    aref_end = 1'b1;
    step();
    aref_end = 1'b0;
    chk("aw_nop", pins(), P_NOP);
    chk("aw_nop_ens", 32'(ens()), 32'h0);
    step();
    chk("aw_wr_en", 32'(ens()), 32'b010);
    chk("aw_wr_pins", pins(), P_WR);
    wr_req = 1'b0;
    wr_end = 1'b1;
    step();
    wr_end = 1'b0;
    chk("aw_end", 32'(ens()), 32'h0);

    // Falling init_end after INIT has no effect
    init_end = 1'b0;
    step(); step();
    chk("ie_low_pins", pins(), P_NOP);
    rd_req = 1'b1; wr_req = 1'b1;
    step();
    chk("ie_low_contest_rd", 32'(ens()), 32'b001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
